// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage: sequential/branch/jump flow,
// a circular return-address stack, soft restart, stall and alignment checks.
module pc_unit #(
   parameter int             N         = 32,
   parameter int             STEP      = 4,
   parameter logic [N-1:0]   RESET_VEC = '0,
   parameter int             DEPTH     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         stall,
   input  logic [2:0]   op,
   input  logic [N-1:0] target,
   input  logic [N-1:0] offset,
   output logic [N-1:0] pc_o,
   output logic [N-1:0] pc_next_o,
   output logic         ras_full,
   output logic         ras_empty,
   output logic         ras_err,
   output logic         misalign_err
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [N-1:0] STEP_V  = N'(STEP);
   localparam logic [N-1:0] ALIGN_M = N'(STEP - 1);
   localparam logic [PW:0]  FULL_C  = (PW + 1)'(DEPTH);
   localparam logic [PW:0]  CNT_ONE = (PW + 1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [2:0] {
      OP_HOLD    = 3'b000,
      OP_SEQ     = 3'b001,
      OP_BRANCH  = 3'b010,
      OP_JUMP    = 3'b011,
      OP_CALL    = 3'b100,
      OP_RET     = 3'b101,
      OP_RESTART = 3'b110,
      OP_RSVD    = 3'b111
   } op_t;

   logic [N-1:0]  pc;
   logic [N-1:0]  ras [DEPTH];
   logic [PW-1:0] top;
   logic [PW:0]   count;

   logic [N-1:0]  pc_seq;
   logic [N-1:0]  pc_br;
   logic [N-1:0]  pc_nxt;
   logic [PW-1:0] top_up;
   logic [PW-1:0] top_dn;
   logic          push;
   logic          pop;
   logic          clr;
   logic          rerr_nxt;
   logic          merr_nxt;

   // Mask is zero when STEP=1, so alignment is never rejected there.
   function automatic logic bad_align(input logic [N-1:0] a);
      return (a & ALIGN_M) != '0;
   endfunction

   assign pc_seq = pc + STEP_V;
   assign pc_br  = pc + offset;
   assign top_up = top + PTR_ONE;
   assign top_dn = top - PTR_ONE;

   assign ras_full  = (count == FULL_C);
   assign ras_empty = (count == '0);

   always_comb begin
      pc_nxt   = pc;
      push     = 1'b0;
      pop      = 1'b0;
      clr      = 1'b0;
      rerr_nxt = 1'b0;
      merr_nxt = 1'b0;
      if (rst) begin
         pc_nxt = RESET_VEC;
      end else if (!stall) begin
         unique case (op_t'(op))
            OP_SEQ: pc_nxt = pc_seq;
            OP_BRANCH: begin
               if (bad_align(pc_br)) merr_nxt = 1'b1;
               else                  pc_nxt   = pc_br;
            end
            OP_JUMP: begin
               if (bad_align(target)) merr_nxt = 1'b1;
               else                   pc_nxt   = target;
            end
            OP_CALL: begin
               if (bad_align(target)) begin
                  merr_nxt = 1'b1;
               end else begin
                  push     = 1'b1;
                  pc_nxt   = target;
                  rerr_nxt = ras_full;
               end
            end
            OP_RET: begin
               if (ras_empty) begin
                  pc_nxt   = pc_seq;
                  rerr_nxt = 1'b1;
               end else begin
                  pop    = 1'b1;
                  pc_nxt = ras[top];
               end
            end
            OP_RESTART: begin
               pc_nxt = RESET_VEC;
               clr    = 1'b1;
            end
            OP_HOLD, OP_RSVD: pc_nxt = pc;
            default: pc_nxt = pc;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc           <= RESET_VEC;
         top          <= '0;
         count        <= '0;
         ras_err      <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         pc           <= pc_nxt;
         ras_err      <= rerr_nxt;
         misalign_err <= merr_nxt;
         if (clr) begin
            top   <= '0;
            count <= '0;
         end else if (push) begin
            // On overflow the pointer wraps onto the oldest entry.
            top <= top_up;
            if (!ras_full) count <= count + CNT_ONE;
         end else if (pop) begin
            top   <= top_dn;
            count <= count - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) ras[top_up] <= pc_seq;
   end

   assign pc_o      = pc;
   assign pc_next_o = pc_nxt;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_pc_unit;

   localparam logic [2:0] HOLD = 3'd0, SEQ = 3'd1, BRANCH = 3'd2,
                          JUMP = 3'd3, CALL = 3'd4, RET = 3'd5,
                          RESTART = 3'd6, RSVD = 3'd7;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       stall = 1'b0;
   logic [2:0] op = HOLD;
   logic [7:0] target = '0;
   logic [7:0] offset = '0;
   logic [7:0] pc_o;
   logic [7:0] pc_next_o;
   logic       ras_full, ras_empty, ras_err, misalign_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] m_pc = 8'h10;
   logic [7:0] m_ras[$];
   logic       m_rerr = 1'b0;
   logic       m_merr = 1'b0;
   logic [7:0] exp_next, obs_next;

   pc_unit #(
      .N(8), .STEP(4), .RESET_VEC(8'h10), .DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .op(op),
      .target(target), .offset(offset),
      .pc_o(pc_o), .pc_next_o(pc_next_o),
      .ras_full(ras_full), .ras_empty(ras_empty),
      .ras_err(ras_err), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   task automatic model_step(input logic r, input logic s,
                             input logic [2:0] o,
                             input logic [7:0] t, input logic [7:0] f);
      logic [7:0] n;
      if (r) begin
         m_pc = 8'h10;
         m_ras.delete();
         m_rerr = 1'b0;
         m_merr = 1'b0;
         return;
      end
      m_rerr = 1'b0;
      m_merr = 1'b0;
      if (s) return;
      case (o)
         SEQ: m_pc = m_pc + 8'd4;
         BRANCH: begin
            n = m_pc + f;
            if (n % 4 != 0) m_merr = 1'b1;
            else m_pc = n;
         end
         JUMP: begin
            if (t % 4 != 0) m_merr = 1'b1;
            else m_pc = t;
         end
         CALL: begin
            if (t % 4 != 0) m_merr = 1'b1;
            else begin
               if (m_ras.size() == 4) begin
                  void'(m_ras.pop_front());
                  m_rerr = 1'b1;
               end
               m_ras.push_back(m_pc + 8'd4);
               m_pc = t;
            end
         end
         RET: begin
            if (m_ras.size() == 0) begin
               m_pc = m_pc + 8'd4;
               m_rerr = 1'b1;
            end else m_pc = m_ras.pop_back();
         end
         RESTART: begin
            m_pc = 8'h10;
            m_ras.delete();
         end
         default: ;
      endcase
   endtask

   // Drive one cycle; capture pc_next_o before the edge, outputs after.
   task automatic cycle(input logic r, input logic s, input logic [2:0] o,
                        input logic [7:0] t, input logic [7:0] f);
      @(negedge clk);
      rst = r; stall = s; op = o; target = t; offset = f;
      #1;
      obs_next = pc_next_o;
      model_step(r, s, o, t, f);
      exp_next = m_pc;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      cycle(1, 0, CALL, 8'h40, 8'h00);
      tests++;
      if ({pc_o, ras_full, ras_empty, ras_err, misalign_err} !==
          {8'h10, 1'b0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset pc=%h f=%b e=%b re=%b me=%b, need 10 0 1 0 0",
                  pc_o, ras_full, ras_empty, ras_err, misalign_err);
      end
   endtask

   task automatic test_seq();
      logic [7:0] e;
      for (int i = 1; i <= 3; i++) begin
         cycle(0, 0, SEQ, 8'h00, 8'h00);
         e = 8'h10 + 8'(4 * i);
         tests++;
         if ({pc_o, ras_empty} !== {e, 1'b1}) begin
            fails++;
            $display("FAIL seq%0d pc=%h empty=%b, need %h 1", i, pc_o, ras_empty, e);
         end
      end
      cycle(0, 0, HOLD, 8'h00, 8'h00);
      tests++;
      if (pc_o !== 8'h1C) begin
         fails++;
         $display("FAIL hold pc=%h, need 1c", pc_o);
      end
      cycle(0, 0, RSVD, 8'h44, 8'h04);
      tests++;
      if (pc_o !== 8'h1C) begin
         fails++;
         $display("FAIL rsvd pc=%h, need 1c", pc_o);
      end
   endtask

   task automatic test_wrap_branch();
      cycle(0, 0, JUMP, 8'hFC, 8'h00);
      cycle(0, 0, SEQ, 8'h00, 8'h00);
      tests++;
      if (pc_o !== 8'h00) begin
         fails++;
         $display("FAIL wrap pc=%h, need 00", pc_o);
      end
      cycle(0, 0, JUMP, 8'h20, 8'h00);
      cycle(0, 0, BRANCH, 8'h00, 8'hF8);
      tests++;
      if ({pc_o, misalign_err} !== {8'h18, 1'b0}) begin
         fails++;
         $display("FAIL branch_back pc=%h me=%b, need 18 0", pc_o, misalign_err);
      end
      cycle(0, 0, BRANCH, 8'h00, 8'h06);
      tests++;
      if ({obs_next, pc_o, misalign_err} !== {8'h18, 8'h18, 1'b1}) begin
         fails++;
         $display("FAIL branch_misalign nxt=%h pc=%h me=%b, need 18 18 1",
                  obs_next, pc_o, misalign_err);
      end
      cycle(0, 0, HOLD, 8'h00, 8'h00);
      tests++;
      if ({pc_o, misalign_err} !== {8'h18, 1'b0}) begin
         fails++;
         $display("FAIL misalign_pulse pc=%h me=%b, need 18 0", pc_o, misalign_err);
      end
      cycle(0, 0, JUMP, 8'h31, 8'h00);
      tests++;
      if ({pc_o, misalign_err} !== {8'h18, 1'b1}) begin
         fails++;
         $display("FAIL jump_misalign pc=%h me=%b, need 18 1", pc_o, misalign_err);
      end
   endtask

   task automatic test_call_ret();
      logic [7:0] exp_pc [4] = '{8'h40, 8'h80, 8'h44, 8'h24};
      logic [2:0] ops [4] = '{CALL, CALL, RET, RET};
      logic [7:0] tg [4] = '{8'h40, 8'h80, 8'h00, 8'h00};
      cycle(0, 0, RESTART, 8'h00, 8'h00);
      cycle(0, 0, JUMP, 8'h20, 8'h00);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, ops[i], tg[i], 8'h00);
         tests++;
         if ({pc_o, ras_err} !== {exp_pc[i], 1'b0}) begin
            fails++;
            $display("FAIL call_ret%0d pc=%h re=%b, need %h 0",
                     i, pc_o, ras_err, exp_pc[i]);
         end
      end
      tests++;
      if (ras_empty !== 1'b1) begin
         fails++;
         $display("FAIL call_ret_empty empty=%b, need 1", ras_empty);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] rets [5] = '{8'h14, 8'h10, 8'h0C, 8'h08, 8'h0C};
      logic [7:0] t;
      cycle(0, 0, RESTART, 8'h00, 8'h00);
      cycle(0, 0, JUMP, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) begin
         t = 8'(4 * (i + 1));
         cycle(0, 0, CALL, t, 8'h00);
         tests++;
         if ({pc_o, ras_full, ras_err} !== {t, 1'(i >= 3), 1'(i == 4)}) begin
            fails++;
            $display("FAIL ovf_call%0d pc=%h full=%b re=%b, need %h %b %b",
                     i, pc_o, ras_full, ras_err, t, i >= 3, i == 4);
         end
      end
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, RET, 8'h00, 8'h00);
         tests++;
         if ({pc_o, ras_err} !== {rets[i], 1'(i == 4)}) begin
            fails++;
            $display("FAIL ovf_ret%0d pc=%h re=%b, need %h %b",
                     i, pc_o, ras_err, rets[i], i == 4);
         end
      end
      cycle(0, 0, HOLD, 8'h00, 8'h00);
      tests++;
      if ({ras_err, ras_empty} !== 2'b01) begin
         fails++;
         $display("FAIL ovf_pulse re=%b empty=%b, need 0 1", ras_err, ras_empty);
      end
   endtask

   task automatic test_stall();
      cycle(0, 0, RESTART, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, CALL, 8'h40, 8'h00);
         tests++;
         if ({obs_next, pc_o, ras_empty} !== {8'h10, 8'h10, 1'b1}) begin
            fails++;
            $display("FAIL stall%0d nxt=%h pc=%h empty=%b, need 10 10 1",
                     i, obs_next, pc_o, ras_empty);
         end
      end
      cycle(0, 0, CALL, 8'h40, 8'h00);
      tests++;
      if ({pc_o, ras_empty} !== {8'h40, 1'b0}) begin
         fails++;
         $display("FAIL stall_release pc=%h empty=%b, need 40 0", pc_o, ras_empty);
      end
   endtask

   task automatic test_rst_restart();
      cycle(1, 1, CALL, 8'h80, 8'h00);
      tests++;
      if ({obs_next, pc_o, ras_empty, ras_err, misalign_err} !==
          {8'h10, 8'h10, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL rst_call nxt=%h pc=%h empty=%b re=%b me=%b, need 10 10 1 0 0",
                  obs_next, pc_o, ras_empty, ras_err, misalign_err);
      end
      cycle(0, 0, CALL, 8'h40, 8'h00);
      cycle(0, 0, CALL, 8'h80, 8'h00);
      cycle(0, 0, RESTART, 8'h00, 8'h00);
      tests++;
      if ({pc_o, ras_empty, ras_err, misalign_err} !== {8'h10, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL restart pc=%h empty=%b re=%b me=%b, need 10 1 0 0",
                  pc_o, ras_empty, ras_err, misalign_err);
      end
   endtask

   task automatic test_random();
      logic r, s;
      logic [2:0] o;
      logic [7:0] t, f;
      for (int i = 0; i < 500; i++) begin
         r = ($urandom % 60) == 0;
         s = ($urandom % 6) == 0;
         o = 3'($urandom);
         t = 8'($urandom);
         f = 8'($urandom);
         if ($urandom % 4 != 0) t[1:0] = 2'b00;
         if ($urandom % 4 != 0) f[1:0] = 2'b00;
         cycle(r, s, o, t, f);
         tests++;
         if (obs_next !== exp_next) begin
            fails++;
            $display("FAIL rnd_next%0d got=%h need=%h", i, obs_next, exp_next);
         end
         tests++;
         if ({pc_o, ras_full, ras_empty, ras_err, misalign_err} !==
             {m_pc, 1'(m_ras.size() == 4), 1'(m_ras.size() == 0), m_rerr, m_merr})
         begin
            fails++;
            $display("FAIL rnd_state%0d pc=%h f=%b e=%b re=%b me=%b, need %h %b %b %b %b",
                     i, pc_o, ras_full, ras_empty, ras_err, misalign_err,
                     m_pc, m_ras.size() == 4, m_ras.size() == 0, m_rerr, m_merr);
         end
      end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_wrap_branch();
      test_call_ret();
      test_overflow();
      test_stall();
      test_rst_restart();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
